// File: rtl/ocx_dlx_tx_gbx.sv
// ----------------------------------------------------------------------------
// ocx_dlx_tx_gbx
// Per-lane TX gearbox (64b/66b). Each accepted 64b scrambled block gets a 2b
// sync header, and the resulting 66b stream is repacked into 64b PHY words.
// 32 blocks fill 33 words, so after 32 accepts the queue is stalled for one
// cycle while the 64b residue is flushed. The queue's parity sideband for the
// accepted block is registered and returned to lane control.
//
// Ports
//   dlx_clk        in   TX lane clock
//   dlx_reset_n    in   async active-low reset
//   ctl_gb_reset   in   sync link reset; restarts the frame
//   ctl_gb_train   in   1 = training block (HDR_CTL), 0 = data (HDR_DATA)
//   que_gb_data    in   64b scrambled block, bit 0 first on the wire
//   que_gb_odd     in   odd parity of the block's payload
//   gb_que_stall   out  queue holds and re-presents its block next cycle
//   gb_phy_data    out  registered 64b PHY word, bit 0 first on the wire
//   gb_ctl_odd     out  registered parity of the last accepted block
//   gb_ctl_odd_v   out  gb_ctl_odd updated this cycle
// ----------------------------------------------------------------------------
module ocx_dlx_tx_gbx #(
    parameter logic [1:0] HDR_DATA = 2'b01,
    parameter logic [1:0] HDR_CTL  = 2'b10
) (
    input  logic        dlx_clk,
    input  logic        dlx_reset_n,
    input  logic        ctl_gb_reset,
    input  logic        ctl_gb_train,
    input  logic [63:0] que_gb_data,
    input  logic        que_gb_odd,
    output logic        gb_que_stall,
    output logic [63:0] gb_phy_data,
    output logic        gb_ctl_odd,
    output logic        gb_ctl_odd_v
);

    logic [5:0]   seq_q, seq_d;
    logic [63:0]  res_q, res_d;
    logic [63:0]  phy_q, phy_d;
    logic         odd_q, odd_d;
    logic         odd_v_q, odd_v_d;

    logic [1:0]   hdr;
    logic [65:0]  blk;
    logic [5:0]   shamt;
    logic [127:0] cat;

    // Values 33..63 are unreachable; decoding >=32 folds them into the stall state.
    assign gb_que_stall = (seq_q >= 6'd32);

    always_comb begin
        hdr   = ctl_gb_train ? HDR_CTL : HDR_DATA;
        blk   = {que_gb_data, hdr};
        // Residue holds 2*seq_q valid bits (upper bits always zero), so the new
        // block lands right above it. Shift is at most 62 on an accept, so
        // 128 bits is enough to hold 66 + 62.
        shamt = {seq_q[4:0], 1'b0};
        cat   = ({62'd0, blk} << shamt) | {64'd0, res_q};

        seq_d   = seq_q;
        res_d   = res_q;
        phy_d   = phy_q;
        odd_d   = odd_q;
        odd_v_d = 1'b0;

        if (ctl_gb_reset) begin
            // Partial frame is dropped; the presented block goes straight out.
            seq_d = 6'd0;
            res_d = 64'd0;
            phy_d = blk[63:0];
        end else if (gb_que_stall) begin
            // Flush the full 64b residue; input is ignored this cycle.
            seq_d = 6'd0;
            res_d = 64'd0;
            phy_d = res_q;
        end else begin
            seq_d   = seq_q + 6'd1;
            phy_d   = cat[63:0];
            res_d   = cat[127:64];
            odd_d   = que_gb_odd;
            odd_v_d = 1'b1;
        end
    end

    always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
        if (!dlx_reset_n) begin
            seq_q   <= 6'd0;
            res_q   <= 64'd0;
            phy_q   <= 64'd0;
            odd_q   <= 1'b0;
            odd_v_q <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            res_q   <= res_d;
            phy_q   <= phy_d;
            odd_q   <= odd_d;
            odd_v_q <= odd_v_d;
        end
    end

    assign gb_phy_data  = phy_q;
    assign gb_ctl_odd   = odd_q;
    assign gb_ctl_odd_v = odd_v_q;

endmodule

// File: tb/tb_ocx_dlx_tx_gbx.sv
// ----------------------------------------------------------------------------
// tb_ocx_dlx_tx_gbx
// Randomized bench for the TX gearbox. The reference keeps the 66b line
// stream as a queue of bits: an accept appends the header and payload bits
// and removes the next 64 as the PHY word, a stall removes the 64 left over,
// and a link reset empties the queue.
// ----------------------------------------------------------------------------
module tb_ocx_dlx_tx_gbx;

    logic        dlx_clk;
    logic        dlx_reset_n;
    logic        ctl_gb_reset;
    logic        ctl_gb_train;
    logic [63:0] que_gb_data;
    logic        que_gb_odd;
    logic        gb_que_stall;
    logic [63:0] gb_phy_data;
    logic        gb_ctl_odd;
    logic        gb_ctl_odd_v;

    ocx_dlx_tx_gbx dut (
        .dlx_clk      (dlx_clk),
        .dlx_reset_n  (dlx_reset_n),
        .ctl_gb_reset (ctl_gb_reset),
        .ctl_gb_train (ctl_gb_train),
        .que_gb_data  (que_gb_data),
        .que_gb_odd   (que_gb_odd),
        .gb_que_stall (gb_que_stall),
        .gb_phy_data  (gb_phy_data),
        .gb_ctl_odd   (gb_ctl_odd),
        .gb_ctl_odd_v (gb_ctl_odd_v)
    );

    initial dlx_clk = 1'b0;
    always #5 dlx_clk = ~dlx_clk;

    int vectors;
    int miscompares;

    // Reference state
    bit          strm[$];
    int          acc_cnt;      // blocks accepted in the current frame
    logic [63:0] exp_phy;
    logic        exp_odd;
    logic        exp_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pop64();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 64; i++)
            if (strm.size() > 0) w[i] = strm.pop_front();
        return w;
    endfunction

    task automatic model_clear();
        strm.delete();
        acc_cnt = 0;
        exp_phy = '0;
        exp_odd = 1'b0;
        exp_v   = 1'b0;
    endtask

    // One clock: drive inputs, check the stall decode, advance the reference,
    // then check registered outputs just after the edge.
    task automatic step(input logic rst, input logic trn, input logic [63:0] d, input logic odd);
        logic [65:0] blk;
        logic        exp_stall;
        ctl_gb_reset = rst;
        ctl_gb_train = trn;
        que_gb_data  = d;
        que_gb_odd   = odd;
        blk          = {d, (trn ? 2'b10 : 2'b01)};
        exp_stall    = (acc_cnt == 32);
        #1;
        chk("stall", {63'd0, gb_que_stall}, {63'd0, exp_stall});
        if (rst) begin
            strm.delete();
            acc_cnt = 0;
            exp_phy = blk[63:0];
            exp_v   = 1'b0;
        end else if (exp_stall) begin
            chk("residue_len", strm.size(), 64);
            exp_phy = pop64();
            acc_cnt = 0;
            exp_v   = 1'b0;
        end else begin
            for (int i = 0; i < 66; i++) strm.push_back(blk[i]);
            exp_phy = pop64();
            acc_cnt++;
            exp_odd = odd;
            exp_v   = 1'b1;
        end
        @(posedge dlx_clk);
        #1;
        chk("phy_data", gb_phy_data, exp_phy);
        chk("ctl_odd", {63'd0, gb_ctl_odd}, {63'd0, exp_odd});
        chk("ctl_odd_v", {63'd0, gb_ctl_odd_v}, {63'd0, exp_v});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] cnt;
        logic        tr;
        vectors      = 0;
        miscompares  = 0;
        dlx_reset_n  = 1'b0;
        ctl_gb_reset = 1'b0;
        ctl_gb_train = 1'b0;
        que_gb_data  = '0;
        que_gb_odd   = 1'b0;
        model_clear();

        repeat (2) @(posedge dlx_clk);
        #1;
        chk("rst_phy", gb_phy_data, 64'd0);
        chk("rst_stall", {63'd0, gb_que_stall}, 64'd0);
        chk("rst_odd", {63'd0, gb_ctl_odd}, 64'd0);
        chk("rst_odd_v", {63'd0, gb_ctl_odd_v}, 64'd0);
        dlx_reset_n = 1'b1;

        // Zero data frames: stream is repeating {64'h0, 2'b01}
        for (int i = 0; i < 66; i++) step(1'b0, 1'b0, 64'd0, 1'b0);

        // Incrementing payload, held while stalled
        cnt = 64'd1;
        for (int i = 0; i < 66; i++) begin
            logic st;
            st = (acc_cnt == 32);
            step(1'b0, 1'b0, cnt, cnt[0]);
            if (!st) cnt++;
        end

        // Training pattern, then train toggling per block
        for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 64'h4A4A_4A4A_4A4A_4A4A, 1'b1);
        tr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, tr, rnd64(), tr);
            tr = ~tr;
        end

        // Link reset at seq 17, then a full frame after it
        while (acc_cnt != 17) step(1'b0, $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));
        step(1'b1, 1'b0, rnd64(), 1'b1);
        for (int i = 0; i < 34; i++) step(1'b0, $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));

        // Link reset coinciding with the stall cycle
        while (acc_cnt != 32) step(1'b0, $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));
        step(1'b1, 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));

        // Async reset mid-frame at seq 9, between edges
        while (acc_cnt != 9) step(1'b0, $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));
        #3;
        dlx_reset_n = 1'b0;
        #1;
        model_clear();
        chk("arst_phy", gb_phy_data, 64'd0);
        chk("arst_stall", {63'd0, gb_que_stall}, 64'd0);
        chk("arst_odd_v", {63'd0, gb_ctl_odd_v}, 64'd0);
        @(posedge dlx_clk);
        #1;
        dlx_reset_n = 1'b1;
        for (int i = 0; i < 66; i++) step(1'b0, 1'b0, 64'd0, 1'b0);

        // Random traffic with occasional link resets
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), rnd64(), $urandom_range(0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
